instr_queue: RTL and testbench
==============================

# instr_queue

Fetch-to-decode instruction queue. Sits directly downstream of the FETCH stage and absorbs its `instruction_out` / `instruction_address_out` / `pc_plus_4_out` / `instruction_valid_out` stream. It buffers up to `DEPTH` fetched words so that decode back-pressure does not stall the fetch stage every cycle, and it presents entries to decode in first-word-fall-through order. It generates FETCH's `stall` input from its own fullness and empties itself on a pipeline flush.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `PTR_W`, `$clog2(DEPTH)`: read/write pointer width; derived, never overridden.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous queue clear; highest priority.
- `instruction_in`  in  `DATA_WIDTH`  fetched instruction word.
- `instruction_address_in`  in  `DATA_WIDTH`  PC of the word.
- `pc_plus_4_in`  in  `DATA_WIDTH`  PC+4 of the word.
- `instruction_valid_in`  in  1  push request from FETCH.
- `decode_ready`  in  1  decode accepts the head entry this cycle.
- `instruction_out`  out  `DATA_WIDTH`  head instruction word.
- `instruction_address_out`  out  `DATA_WIDTH`  head PC.
- `pc_plus_4_out`  out  `DATA_WIDTH`  head PC+4.
- `instruction_valid_out`  out  1  head entry valid (queue non-empty).
- `fetch_stall`  out  1  queue full; drives FETCH `stall`.
- `count`  out  `PTR_W+1`  current occupancy, 0..`DEPTH`.
- `overflow_err`  out  1  sticky flag: a push was attempted while full.

## Operation
- Storage: `DEPTH` entries of {instruction, address, pc_plus_4} (3×`DATA_WIDTH` bits), write pointer `wr_ptr`, read pointer `rd_ptr`, occupancy `count`.
- `push = instruction_valid_in && (count != DEPTH)`.
- `pop = instruction_valid_out && decode_ready`.
- Push: write the entry at `wr_ptr`, then `wr_ptr` += 1, wrapping modulo `DEPTH`.
- Pop: `rd_ptr` += 1, wrapping modulo `DEPTH`.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with a simultaneous pop: the push is refused. No full-bypass; `fetch_stall` is asserted, so FETCH holds.
- Empty with a push: no same-cycle bypass. The entry appears on the outputs the next cycle.
- `instruction_valid_in` while full: the entry is dropped and `overflow_err` is set. It clears only on reset, not on flush.
- `flush`: on the next edge, `count`, `wr_ptr` and `rd_ptr` go to 0. A same-cycle push and pop are both discarded.
- Combinational outputs:
  - `instruction_valid_out = (count != 0)`.
  - `fetch_stall = (count == DEPTH)`.
  - When empty, the three data outputs are forced to 0. Otherwise they show the entry at `rd_ptr`.
- Reset (asynchronous, active-low): pointers 0, `count` 0, `overflow_err` 0, all data outputs 0, `instruction_valid_out` 0, `fetch_stall` 0. Storage contents are don't-care. Reset asserted mid-operation discards all entries immediately.

## Timing
- Push-to-output latency is 1 cycle: data pushed at edge N is visible at the head after edge N if the queue was empty.
- Pop takes effect at the edge. The next entry is presented in the following cycle with no bubble.
- `fetch_stall` rises in the cycle after the push that fills the queue. It falls in the cycle after the first pop from full.
- Sustained throughput is one push and one pop per cycle when 0 < `count` < `DEPTH`.
- After `flush`, `instruction_valid_out` is 0 in the next cycle. A push in that next cycle is accepted normally.

## Structure
- `DATA_WIDTH` comes from the shared constants header `sabit_veriler.vh`.
- Add `IQ_DEPTH` (default 4) to the same header for the top-level instantiation.
- No sub-module: a single module containing the storage array, pointers and the count register.
- Counters and storage use asynchronous-reset `always` blocks; output muxing is a continuous assign.

## Test plan
- **Reset, fill, drain.** Release `reset` and push 0x11, 0x22, 0x33, 0x44 with addresses 0x0, 0x4, 0x8, 0xC, holding `decode_ready`=0. Expect `count`=4 and `fetch_stall`=1, with head 0x11/0x0/0x4. Then raise `decode_ready`: expect outputs 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then `instruction_valid_out`=0 and data outputs = 0.
- **Streaming.** Push every cycle with `decode_ready`=1 for 10 cycles. Expect `count` to stay at 1, no `fetch_stall`, and output order equal to input order with 1-cycle lag.
- **Wrap-around.** Run 9 push/pop cycles with interleaved stalls, so the pointers wrap twice. Expect no reordering and no loss (scoreboard check).
- **Overflow.** With the queue full and `decode_ready`=0, drive a push of 0x55. Expect `overflow_err`=1 and 0x55 never to appear on the outputs. The flag must stay set after a subsequent flush.
- **Flush.** With 3 entries queued, assert `flush` together with a push of 0x66 and `decode_ready`=1. Next cycle expect `count`=0, `instruction_valid_out`=0, and 0x66 discarded.
- **Mid-operation reset.** Pull `reset` low between clock edges with 2 entries queued. Expect all outputs to go to 0 immediately, before the next edge.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// -----------------------------------------------------------------------------
// instr_queue_pkg
//   Shared constants and types for the fetch-to-decode instruction queue.
//   DATA_WIDTH : width of instruction words and addresses.
//   IQ_DEPTH   : default queue depth for the top-level instantiation.
//   iq_entry_t : one buffered fetch word {instruction, address, pc_plus_4}.
// -----------------------------------------------------------------------------
package instr_queue_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int IQ_DEPTH   = 4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instruction;
    logic [DATA_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] pc_plus_4;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue.sv
// -----------------------------------------------------------------------------
// instr_queue
//   First-word-fall-through queue between FETCH and DECODE. Buffers up to
//   DEPTH fetched words, raises fetch_stall when full and empties on flush.
//
//   Ports
//     clk                      in   rising-edge clock
//     reset                    in   asynchronous, active-low reset
//     flush                    in   synchronous clear, highest priority
//     instruction_in           in   fetched instruction word
//     instruction_address_in   in   PC of the word
//     pc_plus_4_in             in   PC+4 of the word
//     instruction_valid_in     in   push request from FETCH
//     decode_ready             in   decode accepts the head entry
//     instruction_out          out  head instruction (0 when empty)
//     instruction_address_out  out  head PC (0 when empty)
//     pc_plus_4_out            out  head PC+4 (0 when empty)
//     instruction_valid_out    out  queue non-empty
//     fetch_stall              out  queue full
//     count                    out  occupancy 0..DEPTH
//     overflow_err             out  sticky: push attempted while full
// -----------------------------------------------------------------------------
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] instruction_in,
  input  logic [DATA_WIDTH-1:0] instruction_address_in,
  input  logic [DATA_WIDTH-1:0] pc_plus_4_in,
  input  logic                  instruction_valid_in,
  input  logic                  decode_ready,
  output logic [DATA_WIDTH-1:0] instruction_out,
  output logic [DATA_WIDTH-1:0] instruction_address_out,
  output logic [DATA_WIDTH-1:0] pc_plus_4_out,
  output logic                  instruction_valid_out,
  output logic                  fetch_stall,
  output logic [$clog2(DEPTH):0] count,
  output logic                  overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  iq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             overflow_reg;

  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  iq_entry_t wr_entry;
  iq_entry_t head_entry;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  // Full queue refuses the push even if decode pops in the same cycle.
  assign push = instruction_valid_in && !full;
  assign pop  = !empty && decode_ready;

  assign wr_entry = '{instruction: instruction_in,
                      address:     instruction_address_in,
                      pc_plus_4:   pc_plus_4_in};

  // Storage. Contents are cleared on reset only to keep simulation X-free;
  // nothing downstream depends on them while the queue is empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  // Pointers and occupancy. DEPTH is a power of two so pointer wrap is the
  // natural overflow of the PTR_W-bit increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Sticky overflow: survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
    end else if (instruction_valid_in && full) begin
      overflow_reg <= 1'b1;
    end
  end

  // Head is forced to zero when empty so stale storage never leaks out,
  // including the instant an asynchronous reset clears the count.
  assign head_entry = empty ? '0 : mem[rd_ptr_reg];

  assign instruction_out         = head_entry.instruction;
  assign instruction_address_out = head_entry.address;
  assign pc_plus_4_out           = head_entry.pc_plus_4;
  assign instruction_valid_out   = !empty;
  assign fetch_stall             = full;
  assign count                   = count_reg;
  assign overflow_err            = overflow_reg;

endmodule

// File: tb/tb_instr_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_queue
//   Directed and randomized stimulus for instr_queue, checked every cycle
//   against a queue-based reference model of the buffer contents.
// -----------------------------------------------------------------------------
module tb_instr_queue;
  import instr_queue_pkg::*;

  localparam int DEPTH = IQ_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  flush;
  logic [DATA_WIDTH-1:0] instruction_in;
  logic [DATA_WIDTH-1:0] instruction_address_in;
  logic [DATA_WIDTH-1:0] pc_plus_4_in;
  logic                  instruction_valid_in;
  logic                  decode_ready;
  logic [DATA_WIDTH-1:0] instruction_out;
  logic [DATA_WIDTH-1:0] instruction_address_out;
  logic [DATA_WIDTH-1:0] pc_plus_4_out;
  logic                  instruction_valid_out;
  logic                  fetch_stall;
  logic [CW-1:0]         count;
  logic                  overflow_err;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the ordered list of words the queue currently holds.
  iq_entry_t model_q[$];
  bit        model_ovf;

  always #5 clk = ~clk;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .flush                   (flush),
    .instruction_in          (instruction_in),
    .instruction_address_in  (instruction_address_in),
    .pc_plus_4_in            (pc_plus_4_in),
    .instruction_valid_in    (instruction_valid_in),
    .decode_ready            (decode_ready),
    .instruction_out         (instruction_out),
    .instruction_address_out (instruction_address_out),
    .pc_plus_4_out           (pc_plus_4_out),
    .instruction_valid_out   (instruction_valid_out),
    .fetch_stall             (fetch_stall),
    .count                   (count),
    .overflow_err            (overflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string phase);
    iq_entry_t head;
    head = (model_q.size() != 0) ? model_q[0] : '0;
    chk({phase, ".instr"}, instruction_out, head.instruction);
    chk({phase, ".addr"},  instruction_address_out, head.address);
    chk({phase, ".pc4"},   pc_plus_4_out, head.pc_plus_4);
    chk({phase, ".valid"}, 32'(instruction_valid_out), 32'(model_q.size() != 0));
    chk({phase, ".stall"}, 32'(fetch_stall), 32'(model_q.size() == DEPTH));
    chk({phase, ".count"}, 32'(count), 32'(model_q.size()));
    chk({phase, ".ovf"},   32'(overflow_err), 32'(model_ovf));
    $display("[%0t] %s v=%0b rdy=%0b fl=%0b -> head=%08h cnt=%0d stall=%0b ovf=%0b",
             $time, phase, instruction_valid_in, decode_ready, flush,
             instruction_out, count, fetch_stall, overflow_err);
  endtask

  // One clock cycle: drive at the falling edge, advance the model by the
  // queue rules, clock, then compare at the next falling edge.
  task automatic step(input string phase, input bit v, input logic [31:0] ins,
                      input logic [31:0] adr, input bit rdy, input bit fl);
    bit was_full;
    bit do_pop;
    instruction_in         = ins;
    instruction_address_in = adr;
    pc_plus_4_in           = adr + 32'd4;
    instruction_valid_in   = v;
    decode_ready           = rdy;
    flush                  = fl;
    was_full = (model_q.size() == DEPTH);
    if (v && was_full) model_ovf = 1'b1;
    if (fl) begin
      model_q.delete();
    end else begin
      do_pop = (model_q.size() != 0) && rdy;
      if (do_pop) void'(model_q.pop_front());
      if (v && !was_full) model_q.push_back('{instruction: ins, address: adr, pc_plus_4: adr + 32'd4});
    end
    @(posedge clk);
    @(negedge clk);
    check_all(phase);
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b0;
    flush = 1'b0;
    instruction_in = '0;
    instruction_address_in = '0;
    pc_plus_4_in = '0;
    instruction_valid_in = 1'b0;
    decode_ready = 1'b0;
    model_ovf = 1'b0;

    // Reset state.
    @(negedge clk);
    check_all("reset");
    reset = 1'b1;

    // Fill to full with decode stalled, then drain in order.
    for (int i = 0; i < 4; i++)
      step("fill", 1'b1, 32'h11 * (i + 1), 32'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step("drain", 1'b0, '0, '0, 1'b1, 1'b0);

    // Streaming: push and pop every cycle, occupancy settles at 1.
    for (int i = 0; i < 10; i++) begin
      step("stream", 1'b1, $urandom, 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
      chk("stream.cnt1", 32'(count), 32'd1);
    end
    step("stream_end", 1'b0, '0, '0, 1'b1, 1'b0);

    // Wrap-around with random stalls on both sides (includes occasional
    // pushes while full).
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      step("random", r[0] | r[1], $urandom, 32'h2000 + 32'(4 * i), r[2], 1'b0);
    end
    for (int i = 0; i < DEPTH + 1; i++)
      step("rdrain", 1'b0, '0, '0, 1'b1, 1'b0);

    // Overflow: fill, push 0x55 while full, drain (0x55 must never show).
    for (int i = 0; i < DEPTH; i++)
      step("ofill", 1'b1, 32'h100 + 32'(i), 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    step("ovf_push", 1'b1, 32'h55, 32'h3100, 1'b0, 1'b0);
    chk("ovf.set", 32'(overflow_err), 32'd1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      step("odrain", 1'b0, '0, '0, 1'b1, 1'b0);
      assert (instruction_out !== 32'h55) else begin
        mismatched++;
        $error("FAIL ovf.leak: observed 0x%08h expected not 0x00000055", instruction_out);
      end
      compared++;
    end
    step("ovf_flush", 1'b0, '0, '0, 1'b0, 1'b1);
    chk("ovf.sticky", 32'(overflow_err), 32'd1);

    // Flush with 3 queued plus a simultaneous push and pop.
    for (int i = 0; i < 3; i++)
      step("pfill", 1'b1, 32'h200 + 32'(i), 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
    step("flush", 1'b1, 32'h66, 32'h4100, 1'b1, 1'b1);
    chk("flush.cnt0", 32'(count), 32'd0);
    step("post_flush", 1'b1, 32'h77, 32'h4200, 1'b0, 1'b0);

    // Mid-operation asynchronous reset with 2 entries queued.
    step("rfill", 1'b1, 32'h88, 32'h5000, 1'b0, 1'b0);
    instruction_valid_in = 1'b0;
    flush = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b1;
    step("after_reset", 1'b1, 32'h99, 32'h6000, 1'b0, 1'b0);
    step("after_reset2", 1'b0, '0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
